// File: rtl/lcd_sw_pkg.sv
// Shared definitions for the front-panel LCD/switch link: FSM encoding,
// default transfer length and chip-select selector values.
package lcd_sw_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int   LCD_SW_DATA_W = 24;

    localparam logic CS_SEL_LCD = 1'b0;
    localparam logic CS_SEL_SW  = 1'b1;

endpackage

// File: rtl/lcd_sw_spi_master.sv
// SPI mode-3 master for the LCD/switch link: MSB-first word out on MOSI,
// word in from MISO, one active-low chip select per downstream device.
module lcd_sw_spi_master
    import lcd_sw_pkg::*;
#(
    parameter int DATA_W   = LCD_SW_DATA_W,
    parameter int CLK_DIV  = 50,
    parameter int CS_SETUP = 10,
    parameter int CS_HOLD  = 10
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_spi_start,
    input  logic [DATA_W-1:0] i_mosi_data,
    input  logic              i_cs_sel,
    output logic [DATA_W-1:0] o_miso_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_sclk,
    output logic              o_mosi,
    input  logic              i_miso,
    output logic              o_lcd_cs_n,
    output logic              o_sw_cs_n
);

    localparam int BIT_W  = $clog2(DATA_W) + 1;
    localparam int HALF_W = $clog2(CLK_DIV) + 1;
    localparam int CS_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int CS_W   = $clog2(CS_MAX) + 1;

    localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(DATA_W - 1);
    localparam logic [HALF_W-1:0] HALF_LAST  = HALF_W'(CLK_DIV - 1);
    localparam logic [CS_W-1:0]   SETUP_LAST = CS_W'(CS_SETUP - 1);
    localparam logic [CS_W-1:0]   HOLD_LAST  = CS_W'(CS_HOLD - 1);

    state_t              r_state;
    logic [DATA_W-1:0]   r_tx;
    logic [DATA_W-1:0]   r_rx;
    logic [BIT_W-1:0]    r_bit;
    logic [HALF_W-1:0]   r_half;
    logic [CS_W-1:0]     r_cs_cnt;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state     <= ST_IDLE;
            r_tx        <= '0;
            r_rx        <= '0;
            r_bit       <= '0;
            r_half      <= '0;
            r_cs_cnt    <= '0;
            o_miso_data <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_sclk      <= 1'b1;
            o_mosi      <= 1'b0;
            o_lcd_cs_n  <= 1'b1;
            o_sw_cs_n   <= 1'b1;
        end else begin
            o_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_spi_start) begin
                        // r_tx keeps only the bits still to be sent, MSB-aligned
                        r_state    <= ST_SETUP;
                        r_tx       <= {i_mosi_data[DATA_W-2:0], 1'b0};
                        r_rx       <= '0;
                        r_cs_cnt   <= '0;
                        o_mosi     <= i_mosi_data[DATA_W-1];
                        o_busy     <= 1'b1;
                        o_lcd_cs_n <= (i_cs_sel != CS_SEL_LCD);
                        o_sw_cs_n  <= (i_cs_sel != CS_SEL_SW);
                    end
                end
                ST_SETUP: begin
                    if (r_cs_cnt == SETUP_LAST) begin
                        r_state <= ST_SHIFT;
                        o_sclk  <= 1'b0;
                        r_half  <= '0;
                        r_bit   <= '0;
                    end else begin
                        r_cs_cnt <= r_cs_cnt + 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (r_half != HALF_LAST) begin
                        r_half <= r_half + 1'b1;
                    end else begin
                        r_half <= '0;
                        if (!o_sclk) begin
                            o_sclk <= 1'b1;
                            r_rx   <= {r_rx[DATA_W-2:0], i_miso};
                        end else if (r_bit == BIT_LAST) begin
                            r_state  <= ST_HOLD;
                            r_cs_cnt <= '0;
                        end else begin
                            o_sclk <= 1'b0;
                            o_mosi <= r_tx[DATA_W-1];
                            r_tx   <= {r_tx[DATA_W-2:0], 1'b0};
                            r_bit  <= r_bit + 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (r_cs_cnt == HOLD_LAST) begin
                        r_state     <= ST_DONE;
                        o_lcd_cs_n  <= 1'b1;
                        o_sw_cs_n   <= 1'b1;
                        o_done      <= 1'b1;
                        o_miso_data <= r_rx;
                        o_mosi      <= 1'b0;
                    end else begin
                        r_cs_cnt <= r_cs_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    o_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
